// File: rtl/disp_pkg.sv
// Shared constants for the 14-segment message scheduler: character codes,
// font patterns and FSM state encoding.
package disp_pkg;

    localparam logic [5:0] CH_SPACE = 6'd0;
    localparam logic [5:0] CH_A     = 6'd1;
    localparam logic [5:0] CH_Z     = 6'd26;
    localparam logic [5:0] CH_0     = 6'd27;
    localparam logic [5:0] CH_9     = 6'd36;

    localparam int unsigned FONT_LEN = 37;

    localparam logic [13:0] SEG_SPACE = 14'b00000000000000;
    localparam logic [13:0] SEG_G     = 14'b10111101000000;
    localparam logic [13:0] SEG_O     = 14'b11111100000000;

    // Bit order: a b c d e f g1 g2 | h j k l m n (inner diagonals/verticals)
    localparam logic [13:0] FONT [FONT_LEN] = '{
        SEG_SPACE,
        14'b11101111000000, 14'b11110001010010, 14'b10011100000000, // A B C
        14'b11110000010010, 14'b10011110000000, 14'b10001110000000, // D E F
        SEG_G,              14'b01101111000000, 14'b10010000010010, // G H I
        14'b01111000000000, 14'b00001110001001, 14'b00011100000000, // J K L
        14'b01101100101000, 14'b01101100100001, SEG_O,              // M N O
        14'b11001111000000, 14'b11111100000001, 14'b11001111000001, // P Q R
        14'b10110111000000, 14'b10000000010010, 14'b01111100000000, // S T U
        14'b00001100001100, 14'b01101100000101, 14'b00000000101101, // V W X
        14'b00000000101010, 14'b10010000001100,                     // Y Z
        14'b11111100001100, 14'b01100000001000, 14'b11011011000000, // 0 1 2
        14'b11110001000000, 14'b01100111000000, 14'b10110111000000, // 3 4 5
        14'b10111111000000, 14'b11100000000000, 14'b11111111000000, // 6 7 8
        14'b11110111000000                                          // 9
    };

    typedef enum logic {
        S_BLANK = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/disp_msg_sched_font.sv
// Combinational character-code to 14-segment decode; codes above '9' are dark.
module seg14_font
    import disp_pkg::*;
(
    input  logic [5:0]  code,
    output logic [13:0] seg
);

    always_comb begin
        seg = '0;
        if (code <= CH_9) seg = FONT[code];
    end

endmodule

// File: rtl/disp_msg_sched.sv
// Double-buffered message scheduler driving a multiplexed 14-segment display.
// Define DISP_SCROLL_EN to enable left scrolling; otherwise the text is static.
module disp_msg_sched
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS        = 12,
    parameter int unsigned MSG_LEN       = 16,
    parameter int unsigned REFRESH_DIV   = 4,
    parameter int unsigned SCROLL_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_addr,
    input  logic [5:0]        wr_char,
    input  logic              commit,
    output logic              commit_pending,
    input  logic              blank,
    output logic              frame_tick,
    output logic [DIGITS-1:0] sel,
    output logic [13:0]       segm
);

    localparam int unsigned AW = $clog2(MSG_LEN);
    localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    if (SCROLL_FRAMES < 1 || REFRESH_DIV < 1 || MSG_LEN < DIGITS ||
        (MSG_LEN & (MSG_LEN - 1)) != 0) begin : g_bad_cfg
        $error("disp_msg_sched: invalid parameter set");
    end

    logic [5:0]        mem [2][MSG_LEN];
    logic              bank;
    state_t            state, state_nxt;
    logic [SW-1:0]     slot_cnt;
    logic [DW-1:0]     dig_idx;
    logic [AW-1:0]     offset, rd_addr;
    logic              slot_wrap, swap, wr_fire;
    logic [5:0]        rd_char;
    logic [13:0]       font_seg, segm_nxt;
    logic [DIGITS-1:0] sel_nxt;

    assign wr_ready   = ~commit_pending;
    assign wr_fire    = wr_valid & wr_ready;
    assign slot_wrap  = (slot_cnt == SW'(REFRESH_DIV - 1));
    assign frame_tick = slot_wrap & (dig_idx == DW'(DIGITS - 1));
    // A commit landing on the tick itself swaps without ever showing as pending
    assign swap       = frame_tick & (commit_pending | commit);
    assign rd_addr    = offset + AW'(dig_idx);
    assign rd_char    = mem[bank][rd_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            dig_idx  <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            dig_idx  <= (dig_idx == DW'(DIGITS - 1)) ? '0 : dig_idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank           <= 1'b0;
            commit_pending <= 1'b0;
        end else if (swap) begin
            bank           <= ~bank;
            commit_pending <= 1'b0;
        end else if (commit) begin
            commit_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned b = 0; b < 2; b++)
                for (int unsigned i = 0; i < MSG_LEN; i++)
                    mem[b[0]][i[AW-1:0]] <= CH_SPACE;
        end else if (wr_fire) begin
            mem[~bank][wr_addr[AW-1:0]] <= wr_char;
        end
    end

`ifdef DISP_SCROLL_EN
    localparam int unsigned FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (swap) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (frame_tick) begin
            if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
                frame_cnt <= '0;
                offset    <= offset + 1'b1;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end
`else
    assign offset = '0;
`endif

    seg14_font u_font (
        .code (rd_char),
        .seg  (font_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_BLANK;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = '0;
        segm_nxt  = '0;
        if (swap) state_nxt = S_RUN;
        if (state == S_RUN && !blank) begin
            sel_nxt  = DIGITS'(1) << dig_idx;
            segm_nxt = font_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel  <= '0;
            segm <= '0;
        end else begin
            sel  <= sel_nxt;
            segm <= segm_nxt;
        end
    end

endmodule

// File: tb/tb_disp_msg_sched.sv
// Directed bench for disp_msg_sched: table-driven frame checks plus
// hand-written commit, blank, scroll and reset sequences.
module tb_disp_msg_sched;
    import disp_pkg::*;

    localparam int unsigned DIGITS = 12;

    logic        clk = 1'b0;
    logic        rst_n, wr_valid, wr_ready, commit, commit_pending, blank, frame_tick;
    logic [3:0]  wr_addr;
    logic [5:0]  wr_char;
    logic [11:0] sel;
    logic [13:0] segm;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    typedef struct {
        int unsigned set;
        logic [3:0]  addr;
        logic [5:0]  ch;
        logic        cm;
        logic [13:0] seg;
    } vec_t;

    vec_t tab [24];

    disp_msg_sched #(
        .DIGITS        (12),
        .MSG_LEN       (16),
        .REFRESH_DIV   (4),
        .SCROLL_FRAMES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_addr        (wr_addr),
        .wr_char        (wr_char),
        .commit         (commit),
        .commit_pending (commit_pending),
        .blank          (blank),
        .frame_tick     (frame_tick),
        .sel            (sel),
        .segm           (segm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_tick !== 1'b1 && n < 200);
        if (frame_tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tick: no frame_tick within 200 cycles");
        end
    endtask

    task automatic write_char(input logic [3:0] a, input logic [5:0] c, input logic cm);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_char  = c;
        commit   = cm;
        @(negedge clk);
        wr_valid = 1'b0;
        commit   = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    // Called on the negedge of the swap tick; walks the whole first frame.
    task automatic check_frame(input int unsigned s);
        @(negedge clk);
        check($sformatf("set%0d pending cleared", s), 32'(commit_pending), 32'd0);
        for (int unsigned d = 0; d < DIGITS; d++) begin
            @(negedge clk);
            check($sformatf("set%0d sel d%0d", s, d), 32'(sel), 32'(12'(1) << d));
            check($sformatf("set%0d segm d%0d", s, d), 32'(segm), 32'(tab[s*12+d].seg));
            repeat (3) @(negedge clk);
            check($sformatf("set%0d sel hold d%0d", s, d), 32'(sel), 32'(12'(1) << d));
        end
    endtask

    initial begin
        int unsigned cyc, ticks;
        logic        dirty;

        // "GONZALE" then spaces
        tab[0]  = '{0, 4'd0,  CH_A + 6'd6,  1'b0, 14'b10111101000000};
        tab[1]  = '{0, 4'd1,  CH_A + 6'd14, 1'b0, 14'b11111100000000};
        tab[2]  = '{0, 4'd2,  CH_A + 6'd13, 1'b0, 14'b01101100100001};
        tab[3]  = '{0, 4'd3,  CH_Z,         1'b0, 14'b10010000001100};
        tab[4]  = '{0, 4'd4,  CH_A,         1'b0, 14'b11101111000000};
        tab[5]  = '{0, 4'd5,  CH_A + 6'd11, 1'b0, 14'b00011100000000};
        tab[6]  = '{0, 4'd6,  CH_A + 6'd4,  1'b0, 14'b10011110000000};
        for (int unsigned i = 7; i < 12; i++)
            tab[i] = '{0, 4'(i), CH_SPACE, 1'b0, 14'b0};
        // "HI 2026", out-of-range code, "QWKM"; last write carries the commit
        tab[12] = '{1, 4'd0,  CH_A + 6'd7,  1'b0, 14'b01101111000000};
        tab[13] = '{1, 4'd1,  CH_A + 6'd8,  1'b0, 14'b10010000010010};
        tab[14] = '{1, 4'd2,  CH_SPACE,     1'b0, 14'b00000000000000};
        tab[15] = '{1, 4'd3,  CH_0 + 6'd2,  1'b0, 14'b11011011000000};
        tab[16] = '{1, 4'd4,  CH_0,         1'b0, 14'b11111100001100};
        tab[17] = '{1, 4'd5,  CH_0 + 6'd2,  1'b0, 14'b11011011000000};
        tab[18] = '{1, 4'd6,  CH_0 + 6'd6,  1'b0, 14'b10111111000000};
        tab[19] = '{1, 4'd7,  CH_9 + 6'd4,  1'b0, 14'b00000000000000};
        tab[20] = '{1, 4'd8,  CH_A + 6'd16, 1'b0, 14'b11111100000001};
        tab[21] = '{1, 4'd9,  CH_A + 6'd22, 1'b0, 14'b01101100000101};
        tab[22] = '{1, 4'd10, CH_A + 6'd10, 1'b0, 14'b00001110001001};
        tab[23] = '{1, 4'd11, CH_A + 6'd12, 1'b1, 14'b01101100101000};

        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_char = '0;
        commit = 1'b0; blank = 1'b0;
        repeat (3) @(negedge clk);
        check("reset sel", 32'(sel), 32'd0);
        check("reset segm", 32'(segm), 32'd0);
        check("reset frame_tick", 32'(frame_tick), 32'd0);
        check("reset pending", 32'(commit_pending), 32'd0);
        check("reset wr_ready", 32'(wr_ready), 32'd1);
        rst_n = 1'b1;

        // Idle: dark display, frame_tick every 48 cycles
        cyc = 0; ticks = 0; dirty = 1'b0;
        for (int unsigned c = 0; c < 200; c++) begin
            @(negedge clk);
            cyc++;
            if (sel !== '0 || segm !== '0 || wr_ready !== 1'b1) dirty = 1'b1;
            if (frame_tick === 1'b1) begin
                if (ticks > 0) check("tick interval", cyc, 32'd48);
                ticks++;
                cyc = 0;
            end
        end
        check("idle outputs dark", 32'(dirty), 32'd0);
        check("idle tick count >= 4", 32'(ticks >= 4), 32'd1);

        // Table-driven loads: each set written to shadow, committed, frame checked
        for (int unsigned s = 0; s < 2; s++) begin
            wait_tick();
            for (int unsigned i = 0; i < 24; i++)
                if (tab[i].set == s) write_char(tab[i].addr, tab[i].ch, tab[i].cm);
            if (s == 0) begin
                pulse_commit();
                check("set0 dark before swap", 32'(sel), 32'd0);
            end
            check($sformatf("set%0d pending after commit", s), 32'(commit_pending), 32'd1);
            check($sformatf("set%0d wr_ready while pending", s), 32'(wr_ready), 32'd0);
            wait_tick();
            check_frame(s);
        end

        // Second commit while pending is ignored, as is a write it carries
        wait_tick();
        write_char(4'd0, CH_A + 6'd23, 1'b0);
        pulse_commit();
        check("dup: pending", 32'(commit_pending), 32'd1);
        commit = 1'b1; wr_valid = 1'b1; wr_addr = 4'd1; wr_char = CH_A + 6'd16;
        #1 check("dup: wr_ready low", 32'(wr_ready), 32'd0);
        @(negedge clk);
        commit = 1'b0; wr_valid = 1'b0;
        check("dup: still pending", 32'(commit_pending), 32'd1);
        wait_tick();
        repeat (2) @(negedge clk);
        check("dup: digit0 X", 32'(segm), 32'(14'b00000000101101));
        repeat (4) @(negedge clk);
        check("dup: digit1 unchanged O", 32'(segm), 32'(14'b11111100000000));
        wait_tick();
        repeat (2) @(negedge clk);
        check("dup: no second swap", 32'(segm), 32'(14'b00000000101101));
        check("dup: pending clear", 32'(commit_pending), 32'd0);

        // Scroll and blank: reload GONZALE into all 16 slots, then track frames
        wait_tick();
        for (int unsigned i = 0; i < 16; i++)
            write_char(4'(i), (i < 12) ? tab[i].ch : CH_SPACE, 1'b0);
        pulse_commit();
        wait_tick();
        wait_tick();
        wait_tick();
        blank = 1'b1;
        dirty = 1'b0;
        for (int unsigned c = 0; c < 48; c++) begin
            @(negedge clk);
            if (sel !== '0 || segm !== '0) dirty = 1'b1;
        end
        check("blank: display dark", 32'(dirty), 32'd0);
        check("blank: tick keeps running", 32'(frame_tick), 32'd1);
        blank = 1'b0;
        repeat (2) @(negedge clk);
        check("frame4 sel", 32'(sel), 32'h001);
`ifdef DISP_SCROLL_EN
        check("frame4 digit0", 32'(segm), 32'(14'b11111100000000));
`else
        check("frame4 digit0", 32'(segm), 32'(14'b10111101000000));
`endif
        wait_tick();
        repeat (2) @(negedge clk);
`ifdef DISP_SCROLL_EN
        check("frame5 digit0", 32'(segm), 32'(14'b01101100100001));
`else
        check("frame5 digit0", 32'(segm), 32'(14'b10111101000000));
`endif
        repeat (27) wait_tick();
        repeat (2) @(negedge clk);
`ifdef DISP_SCROLL_EN
        check("frame32 digit0", 32'(segm), 32'd0);
`else
        check("frame32 digit0", 32'(segm), 32'(14'b10111101000000));
`endif
        wait_tick();
        repeat (2) @(negedge clk);
        check("frame33 digit0 wrap", 32'(segm), 32'(14'b10111101000000));
        repeat (4) @(negedge clk);
        check("frame33 digit1", 32'(segm), 32'(14'b11111100000000));

        // Reset at cycle 20 of a frame with a commit pending
        wait_tick();
        @(negedge clk);
        pulse_commit();
        repeat (18) @(negedge clk);
        check("pre-reset pending", 32'(commit_pending), 32'd1);
        check("pre-reset sel", 32'(sel), 32'h010);
        rst_n = 1'b0;
        #1;
        check("async reset sel", 32'(sel), 32'd0);
        check("async reset segm", 32'(segm), 32'd0);
        check("async reset pending", 32'(commit_pending), 32'd0);
        check("async reset frame_tick", 32'(frame_tick), 32'd0);
        check("async reset wr_ready", 32'(wr_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        dirty = 1'b0;
        for (int unsigned c = 0; c < 150; c++) begin
            @(negedge clk);
            if (sel !== '0 || commit_pending !== 1'b0) dirty = 1'b1;
        end
        check("post-reset stays blank", 32'(dirty), 32'd0);
        // Commit on the tick cycle itself swaps at once; banks must read as spaces
        wait_tick();
        commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
        check("tick commit: no pending", 32'(commit_pending), 32'd0);
        @(negedge clk);
        check("tick commit sel", 32'(sel), 32'h001);
        check("cleared bank digit0", 32'(segm), 32'd0);
        repeat (4) @(negedge clk);
        check("cleared bank digit1", 32'(segm), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
